// File: rtl/mips32_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: requester IDs,
// FSM state encoding and the width of the tag carried in the read FIFO.
package mips32_arb_pkg;

    localparam int ID_W = 2;

    typedef logic [ID_W-1:0] req_id_t;

    localparam req_id_t REQ_D = 2'd0;
    localparam req_id_t REQ_I = 2'd1;
    localparam req_id_t REQ_L = 2'd2;

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mips32_arb_tag_fifo.sv
// In-order tag FIFO holding the requester ID of every read in flight.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Push and pop in the same cycle are both honoured; a push into a full
// FIFO is dropped unless a pop frees a slot in the same cycle.
module mips32_arb_tag_fifo
    import mips32_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic            clk1,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] head_id,
    output logic [CNT_W-1:0] count,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [ID_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign head_id = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Arbiter for the single-ported unified instruction/data memory shared by
// the MEM-stage data port (d_), the IF-stage fetch port (i_) and the
// external loader/debug port (l_). Grants double as pipeline stall sources.
// Read responses are routed back in order through a tag FIFO.
// Optional build macro MIPS32_ARB_PERF_EN adds grant/conflict counters.
//
// state  | meaning
// RUN    | normal arbitration, priority d > i > l with starvation promotion
// DRAIN  | loader asked for the bus; no grants until reads in flight return
// LOCKED | loader owns the memory exclusively; locked=1
module mips32_mem_arbiter
    import mips32_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    input  logic                     d_req,
    input  logic                     i_req,
    input  logic                     l_req,
    input  logic                     d_we,
    input  logic                     l_we,
    input  logic [ADDR_W-1:0]        d_addr,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [ADDR_W-1:0]        l_addr,
    input  logic [31:0]              d_wdata,
    input  logic [31:0]              l_wdata,
    output logic                     d_gnt,
    output logic                     i_gnt,
    output logic                     l_gnt,
    output logic                     d_rvalid,
    output logic                     i_rvalid,
    output logic                     l_rvalid,
    output logic [31:0]              rdata,
    input  logic                     l_lock,
    output logic                     locked,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ready,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic                     err_orphan
`ifdef MIPS32_ARB_PERF_EN
    ,
    output logic [31:0]              perf_d_gnt,
    output logic [31:0]              perf_i_gnt,
    output logic [31:0]              perf_l_gnt,
    output logic [31:0]              perf_conflict
`endif
);

    localparam int OUT_W = $clog2(MAX_OUT) + 1;
    localparam int SC_W  = $clog2(STARVE_LIM + 1);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  req_vec, we_vec, elig_vec, promo_vec, gnt_vec;
    logic [SC_W-1:0]     starve_q [NUM_REQ];
    logic [SC_W-1:0]     starve_d [NUM_REQ];
    logic                sel_valid;
    req_id_t             sel_id;
    logic                accept;
    logic                fifo_push, fifo_empty, fifo_full;
    req_id_t             fifo_head;
    logic [OUT_W-1:0]    fifo_count;
    logic                err_orphan_q, err_orphan_d;

    assign req_vec[REQ_D] = d_req;
    assign req_vec[REQ_I] = i_req;
    assign req_vec[REQ_L] = l_req;
    assign we_vec[REQ_D]  = d_we;
    assign we_vec[REQ_I]  = 1'b0;
    assign we_vec[REQ_L]  = l_we;

    // Eligibility: writes always pass, reads need a free tag slot; the FSM
    // then masks who may compete at all.
    always_comb begin
        elig_vec  = '0;
        promo_vec = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            promo_vec[k] = (starve_q[k] == SC_W'(STARVE_LIM));
            elig_vec[k]  = req_vec[k] && (we_vec[k] || !fifo_full);
        end
        case (state_q)
            RUN:     elig_vec = elig_vec;
            LOCKED:  elig_vec = elig_vec & (NUM_REQ'(1) << REQ_L);
            default: elig_vec = '0;
        endcase
    end

    // Priority select: promoted i, promoted l, then base order d > i > l.
    always_comb begin
        sel_valid = 1'b1;
        sel_id    = REQ_D;
        if (elig_vec[REQ_I] && promo_vec[REQ_I])      sel_id = REQ_I;
        else if (elig_vec[REQ_L] && promo_vec[REQ_L]) sel_id = REQ_L;
        else if (elig_vec[REQ_D])                     sel_id = REQ_D;
        else if (elig_vec[REQ_I])                     sel_id = REQ_I;
        else if (elig_vec[REQ_L])                     sel_id = REQ_L;
        else                                          sel_valid = 1'b0;
    end

    // Memory-side request mux from the selected requester.
    always_comb begin
        mem_addr  = d_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (sel_id)
            REQ_D: begin
                mem_addr  = d_addr;
                mem_we    = d_we;
                mem_wdata = d_wdata;
            end
            REQ_I: begin
                mem_addr  = i_addr;
                mem_we    = 1'b0;
                mem_wdata = '0;
            end
            REQ_L: begin
                mem_addr  = l_addr;
                mem_we    = l_we;
                mem_wdata = l_wdata;
            end
            default: begin
                mem_addr  = d_addr;
                mem_we    = 1'b0;
                mem_wdata = '0;
            end
        endcase
    end

    // Requests and grants are held off while reset is asserted so the
    // pipeline sees no grant even with requests still pending.
    assign mem_req   = sel_valid && rst_n;
    assign accept    = mem_req && mem_ready;
    assign fifo_push = accept && !mem_we;

    // One-hot grant decode from the accepted selection.
    always_comb begin
        gnt_vec = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt_vec[k] = accept && (sel_id == req_id_t'(k));
        end
    end

    assign d_gnt = gnt_vec[REQ_D];
    assign i_gnt = gnt_vec[REQ_I];
    assign l_gnt = gnt_vec[REQ_L];

    mips32_arb_tag_fifo #(
        .DEPTH (MAX_OUT),
        .CNT_W (OUT_W)
    ) u_tag_fifo (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .push_id (sel_id),
        .pop     (mem_rvalid),
        .head_id (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign outstanding = fifo_count;
    assign rdata       = mem_rdata;
    assign d_rvalid    = mem_rvalid && !fifo_empty && (fifo_head == REQ_D);
    assign i_rvalid    = mem_rvalid && !fifo_empty && (fifo_head == REQ_I);
    assign l_rvalid    = mem_rvalid && !fifo_empty && (fifo_head == REQ_L);

    // A response with nothing in flight is a protocol error; remember it.
    assign err_orphan_d = err_orphan_q || (mem_rvalid && fifo_empty);
    assign err_orphan   = err_orphan_q;

    // Starvation counters: count denied cycles, saturate at the limit,
    // clear on grant or when the request goes away.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            starve_d[k] = '0;
            if (req_vec[k] && !gnt_vec[k]) begin
                starve_d[k] = promo_vec[k] ? starve_q[k] : starve_q[k] + 1'b1;
            end
        end
    end

    // Loader ownership FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (l_lock && l_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!l_lock)                 state_d = RUN;
                else if (fifo_count == '0)   state_d = LOCKED;
            end
            LOCKED: begin
                if (!l_lock) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign locked = (state_q == LOCKED);

    // Arbiter state registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            err_orphan_q <= 1'b0;
            for (int k = 0; k < NUM_REQ; k++) starve_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            err_orphan_q <= err_orphan_d;
            for (int k = 0; k < NUM_REQ; k++) starve_q[k] <= starve_d[k];
        end
    end

`ifdef MIPS32_ARB_PERF_EN
    logic [31:0] perf_d_gnt_q, perf_d_gnt_d;
    logic [31:0] perf_i_gnt_q, perf_i_gnt_d;
    logic [31:0] perf_l_gnt_q, perf_l_gnt_d;
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic        conflict;

    assign conflict = (d_req && i_req) || (d_req && l_req) || (i_req && l_req);

    // Wrapping event counters.
    always_comb begin
        perf_d_gnt_d    = perf_d_gnt_q + {31'd0, d_gnt};
        perf_i_gnt_d    = perf_i_gnt_q + {31'd0, i_gnt};
        perf_l_gnt_d    = perf_l_gnt_q + {31'd0, l_gnt};
        perf_conflict_d = perf_conflict_q + {31'd0, conflict};
    end

    // Performance counter registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            perf_d_gnt_q    <= '0;
            perf_i_gnt_q    <= '0;
            perf_l_gnt_q    <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_d_gnt_q    <= perf_d_gnt_d;
            perf_i_gnt_q    <= perf_i_gnt_d;
            perf_l_gnt_q    <= perf_l_gnt_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_d_gnt    = perf_d_gnt_q;
    assign perf_i_gnt    = perf_i_gnt_q;
    assign perf_l_gnt    = perf_l_gnt_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter. A behavioural memory with
// fixed read latency answers granted reads; expected responses are queued
// when reads are issued and popped as the arbiter routes responses back.
module tb_mips32_mem_arbiter;
    import mips32_arb_pkg::*;

    localparam int ADDR_W     = 10;
    localparam int MAX_OUT    = 4;
    localparam int STARVE_LIM = 8;
    localparam int LAT        = 2;

    logic              clk1 = 1'b0;
    logic              rst_n;
    logic              d_req, i_req, l_req, d_we, l_we, l_lock;
    logic [ADDR_W-1:0] d_addr, i_addr, l_addr;
    logic [31:0]       d_wdata, l_wdata;
    logic              d_gnt, i_gnt, l_gnt, d_rvalid, i_rvalid, l_rvalid;
    logic [31:0]       rdata;
    logic              locked, mem_req, mem_we, mem_ready, mem_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [$clog2(MAX_OUT):0] outstanding;
    logic              err_orphan;
`ifdef MIPS32_ARB_PERF_EN
    logic [31:0]       perf_d_gnt, perf_i_gnt, perf_l_gnt, perf_conflict;
`endif

    mips32_mem_arbiter #(
        .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk1(clk1), .rst_n(rst_n),
        .d_req(d_req), .i_req(i_req), .l_req(l_req),
        .d_we(d_we), .l_we(l_we),
        .d_addr(d_addr), .i_addr(i_addr), .l_addr(l_addr),
        .d_wdata(d_wdata), .l_wdata(l_wdata),
        .d_gnt(d_gnt), .i_gnt(i_gnt), .l_gnt(l_gnt),
        .d_rvalid(d_rvalid), .i_rvalid(i_rvalid), .l_rvalid(l_rvalid),
        .rdata(rdata), .l_lock(l_lock), .locked(locked),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .outstanding(outstanding), .err_orphan(err_orphan)
`ifdef MIPS32_ARB_PERF_EN
        , .perf_d_gnt(perf_d_gnt), .perf_i_gnt(perf_i_gnt),
        .perf_l_gnt(perf_l_gnt), .perf_conflict(perf_conflict)
`endif
    );

    always #5 clk1 = ~clk1;

    typedef struct { logic [1:0] id; logic [31:0] data; } exp_t;
    typedef struct { int due; logic [31:0] data; } rsp_t;

    exp_t        sb[$];
    rsp_t        rq[$];
    logic [31:0] model [1024];
    int          cyc, n_checks, n_pass;
    bit          resp_hold, orphan_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [31:0] rv_id(input logic [2:0] rv);
        case (rv)
            3'b001:  return 32'd0;
            3'b010:  return 32'd1;
            3'b100:  return 32'd2;
            default: return 32'd3;
        endcase
    endfunction

    task automatic push_exp(input logic [1:0] id, input logic [ADDR_W-1:0] a);
        exp_t e;
        e.id   = id;
        e.data = model[a];
        sb.push_back(e);
    endtask

    task automatic at_sample;
        @(negedge clk1);
    endtask

    // Response monitor + memory model update, then advance one clock.
    task automatic next_cycle;
        logic [2:0] rv;
        exp_t       e;
        rsp_t       r;
        rv = {l_rvalid, i_rvalid, d_rvalid};
        if (mem_rvalid) begin
            if (orphan_mode) check("orphan_rv", {29'd0, rv}, 32'd0);
            else if (sb.size() == 0) check("rsp_unexpected", {29'd0, rv}, 32'd0);
            else begin
                e = sb.pop_front();
                check("rsp_id", rv_id(rv), {30'd0, e.id});
                check("rsp_data", rdata, e.data);
            end
        end else begin
            check("rsp_idle", {29'd0, rv}, 32'd0);
        end
        if (mem_req && mem_ready) begin
            if (mem_we) model[mem_addr] = mem_wdata;
            else begin
                r.due  = cyc + LAT;
                r.data = model[mem_addr];
                rq.push_back(r);
            end
        end
        @(posedge clk1);
        #1;
        cyc++;
        if (!resp_hold && rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = r.data;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
    endtask

    task automatic cycle;
        at_sample();
        next_cycle();
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((sb.size() > 0 || rq.size() > 0) && n < 30) begin
            cycle();
            n++;
        end
        at_sample();
        check("drain_left", sb.size(), 32'd0);
        check("drain_out", {29'd0, outstanding}, 32'd0);
        next_cycle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int  n;
        bit  found;
        cyc = 0; n_checks = 0; n_pass = 0; resp_hold = 0; orphan_mode = 0;
        for (int a = 0; a < 1024; a++) model[a] = 32'hA500_0000 ^ (a * 32'h0001_0003);
        rst_n = 0; d_req = 0; i_req = 0; l_req = 0; d_we = 0; l_we = 0; l_lock = 0;
        d_addr = '0; i_addr = '0; l_addr = '0; d_wdata = '0; l_wdata = '0;
        mem_ready = 1; mem_rvalid = 0; mem_rdata = '0;

        // Reset state, with a request pending to show grants are held off.
        d_req = 1;
        at_sample();
        check("rst_out", {29'd0, outstanding}, 32'd0);
        check("rst_gnt", {29'd0, d_gnt, i_gnt, l_gnt}, 32'd0);
        check("rst_memreq", {31'd0, mem_req}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_orphan", {31'd0, err_orphan}, 32'd0);
        next_cycle();
        d_req = 0; rst_n = 1;
        cycle();

        // mem_ready low: request presented but not granted.
        d_req = 1; d_we = 0; d_addr = 10'd5; mem_ready = 0;
        at_sample();
        check("nrdy_gnt", {31'd0, d_gnt}, 32'd0);
        check("nrdy_memreq", {31'd0, mem_req}, 32'd1);
        check("nrdy_addr", {22'd0, mem_addr}, 32'd5);
        next_cycle();
        mem_ready = 1; push_exp(REQ_D, 10'd5);
        at_sample();
        check("rdy_gnt", {31'd0, d_gnt}, 32'd1);
        next_cycle();
        d_req = 0;
        drain();

        // d and i reads together: d first, then i; responses in order.
        d_req = 1; d_addr = 10'd10; i_req = 1; i_addr = 10'd20;
        push_exp(REQ_D, 10'd10); push_exp(REQ_I, 10'd20);
        at_sample();
        check("pri_d_gnt", {31'd0, d_gnt}, 32'd1);
        check("pri_i_wait", {31'd0, i_gnt}, 32'd0);
        check("pri_out0", {29'd0, outstanding}, 32'd0);
        next_cycle();
        d_req = 0;
        at_sample();
        check("pri_i_gnt", {31'd0, i_gnt}, 32'd1);
        check("pri_out1", {29'd0, outstanding}, 32'd1);
        next_cycle();
        i_req = 0;
        drain();

        // Starvation: d writes every cycle, i wins on its 9th requesting cycle.
        d_req = 1; d_we = 1; d_addr = 10'd100; d_wdata = 32'hCAFE_0001;
        i_req = 1; i_addr = 10'd30; push_exp(REQ_I, 10'd30);
        for (int k = 1; k <= 9; k++) begin
            at_sample();
            check("stv_i_gnt", {31'd0, i_gnt}, {31'd0, k == 9});
            check("stv_d_gnt", {31'd0, d_gnt}, {31'd0, k != 9});
            next_cycle();
        end
        i_addr = 10'd31; push_exp(REQ_I, 10'd31);
        n = 0; found = 0;
        while (!found && n < 20) begin
            n++;
            at_sample();
            if (i_gnt) found = 1;
            next_cycle();
        end
        check("stv_again", n, 32'd9);
        d_req = 0; d_we = 0; i_req = 0;
        drain();

        // Tag FIFO full: reads blocked, a write still passes.
        resp_hold = 1; i_req = 1;
        for (int k = 0; k < 4; k++) begin
            i_addr = ADDR_W'(40 + k); push_exp(REQ_I, ADDR_W'(40 + k));
            at_sample();
            check("full_fill_gnt", {31'd0, i_gnt}, 32'd1);
            next_cycle();
        end
        i_addr = 10'd44; push_exp(REQ_I, 10'd44);
        d_req = 1; d_we = 1; d_addr = 10'd200; d_wdata = 32'h5555_AAAA;
        at_sample();
        check("full_i_blk", {31'd0, i_gnt}, 32'd0);
        check("full_out", {29'd0, outstanding}, 32'd4);
        check("full_d_wr", {31'd0, d_gnt}, 32'd1);
        next_cycle();
        d_req = 0; d_we = 0;
        at_sample();
        check("full_idle_req", {31'd0, mem_req}, 32'd0);
        next_cycle();
        resp_hold = 0;
        n = 0; found = 0;
        while (!found && n < 20) begin
            n++;
            at_sample();
            if (i_gnt) found = 1;
            next_cycle();
        end
        check("full_regrant", {31'd0, found}, 32'd1);
        i_req = 0;
        drain();

        // Lock sequence with reads in flight.
        resp_hold = 1;
        d_req = 1; d_addr = 10'd50; i_req = 1; i_addr = 10'd51;
        push_exp(REQ_D, 10'd50); push_exp(REQ_I, 10'd51);
        at_sample();
        check("lk_d_gnt", {31'd0, d_gnt}, 32'd1);
        next_cycle();
        d_req = 0;
        at_sample();
        check("lk_i_gnt", {31'd0, i_gnt}, 32'd1);
        next_cycle();
        i_req = 0;
        l_lock = 1; l_req = 1; l_we = 0; l_addr = 10'd60; push_exp(REQ_L, 10'd60);
        at_sample();
        check("lk_run_l_gnt", {31'd0, l_gnt}, 32'd1);
        check("lk_run_unlocked", {31'd0, locked}, 32'd0);
        next_cycle();
        l_addr = 10'd61; i_req = 1; i_addr = 10'd52;
        push_exp(REQ_L, 10'd61); push_exp(REQ_I, 10'd52);
        for (int k = 0; k < 3; k++) begin
            at_sample();
            check("drain_nogrant", {29'd0, d_gnt, i_gnt, l_gnt}, 32'd0);
            check("drain_unlocked", {31'd0, locked}, 32'd0);
            next_cycle();
        end
        resp_hold = 0;
        n = 0;
        at_sample();
        while (!locked && n < 12) begin
            check("drain_gnt", {29'd0, d_gnt, i_gnt, l_gnt}, 32'd0);
            next_cycle();
            n++;
            at_sample();
        end
        check("lk_reached", {31'd0, locked}, 32'd1);
        check("lk_out0", {29'd0, outstanding}, 32'd0);
        check("lk_l_gnt", {31'd0, l_gnt}, 32'd1);
        check("lk_i_blk", {31'd0, i_gnt}, 32'd0);
        next_cycle();
        l_lock = 0; l_req = 0;
        at_sample();
        check("unlk_still", {31'd0, locked}, 32'd1);
        check("unlk_i_blk", {31'd0, i_gnt}, 32'd0);
        next_cycle();
        at_sample();
        check("unlk_run", {31'd0, locked}, 32'd0);
        check("unlk_i_gnt", {31'd0, i_gnt}, 32'd1);
        next_cycle();
        i_req = 0;
        drain();

        // Orphan response: no rvalid, sticky error.
        orphan_mode = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        at_sample();
        check("orph_rv_now", {29'd0, l_rvalid, i_rvalid, d_rvalid}, 32'd0);
        next_cycle();
        orphan_mode = 0;
        at_sample();
        check("orph_set", {31'd0, err_orphan}, 32'd1);
        next_cycle();
        repeat (3) cycle();
        at_sample();
        check("orph_sticky", {31'd0, err_orphan}, 32'd1);
        next_cycle();

        // Reset mid-stream with 3 reads in flight.
        resp_hold = 1; i_req = 1;
        for (int k = 0; k < 3; k++) begin
            i_addr = ADDR_W'(70 + k);
            at_sample();
            check("mrst_fill", {31'd0, i_gnt}, 32'd1);
            next_cycle();
        end
        at_sample();
        check("mrst_out3", {29'd0, outstanding}, 32'd3);
        rst_n = 0;
        #1;
        check("mrst_out0", {29'd0, outstanding}, 32'd0);
        check("mrst_gnt", {29'd0, d_gnt, i_gnt, l_gnt}, 32'd0);
        check("mrst_memreq", {31'd0, mem_req}, 32'd0);
        check("mrst_orphan", {31'd0, err_orphan}, 32'd0);
        rq.delete();
        resp_hold = 0;
        next_cycle();
        i_req = 0; rst_n = 1;
        d_req = 1; d_we = 0; d_addr = 10'd80; push_exp(REQ_D, 10'd80);
        at_sample();
        check("post_rst_gnt", {31'd0, d_gnt}, 32'd1);
        check("post_rst_out", {29'd0, outstanding}, 32'd0);
        next_cycle();
        d_req = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
